// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls plus a state debug port.
// Optional ORI support (DECODE->ORIEX->ADDIWB) is compiled in when MIPS_CTRL_ORI_EN is defined.
module mips_mc_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    alu_src_a,
  output logic                    ext_sign,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_src,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state_dbg
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH  = STATE_WIDTH'(0),
    DECODE = STATE_WIDTH'(1),
    MEMADR = STATE_WIDTH'(2),
    MEMRD  = STATE_WIDTH'(3),
    MEMWB  = STATE_WIDTH'(4),
    MEMWR  = STATE_WIDTH'(5),
    EXEC   = STATE_WIDTH'(6),
    ALUWB  = STATE_WIDTH'(7),
    BRANCH = STATE_WIDTH'(8),
    ADDIEX = STATE_WIDTH'(9),
    ADDIWB = STATE_WIDTH'(10),
`ifdef MIPS_CTRL_ORI_EN
    JUMP   = STATE_WIDTH'(11),
    ORIEX  = STATE_WIDTH'(12)
`else
    JUMP   = STATE_WIDTH'(11)
`endif
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
`ifdef MIPS_CTRL_ORI_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'b001101);
`endif

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  assign state_dbg = state;

  always_comb begin
    state_next    = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    ext_sign      = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    case (state)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_sign  = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
`ifdef MIPS_CTRL_ORI_EN
          OP_ORI:       state_next = ORIEX;
`endif
          default: begin
            illegal_op = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sign  = 1'b1;
        // IR is stable here, so re-sampling the opcode picks the load/store leg.
        if (opcode == OP_LW)      state_next = MEMRD;
        else if (opcode == OP_SW) state_next = MEMWR;
        else                      state_next = FETCH;
      end
      MEMRD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        state_next = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        ext_sign   = 1'b1;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
`ifdef MIPS_CTRL_ORI_EN
      ORIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 2'b11;
        state_next = ADDIWB;
      end
`endif
      default: state_next = FETCH;
    endcase
    // Reset masks every control combinationally, even before the first edge.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      ext_sign      = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter OPCODE_WIDTH, default 6: instruction opcode field width; all opcode constants are compared at this width.
REQ-002 Parameter STATE_WIDTH, default 4: width of the state register and the state_dbg port.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 opcode  input  OPCODE_WIDTH  IR[31:26], sampled in DECODE.
REQ-006 mem_ready  input  1  memory handshake; the access in the current memory state completes this cycle.
REQ-007 Strobe outputs, 1 bit each: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, ext_sign.
REQ-008 Select outputs, 2 bits each: alu_src_b, alu_op, pc_src.
REQ-009 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-010 state_dbg  output  STATE_WIDTH  current state encoding.

Function
REQ-011 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ORIEX=12; encodings 13-15 are unused and SHALL transition to FETCH.
REQ-012 Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010, ORI=001101.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write equal mem_ready; the FSM stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_sign=1; next state is chosen by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, ORI->ORIEX (macro only).
REQ-015 DECODE with any other opcode: illegal_op=1 for exactly that cycle; next state FETCH.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_sign=1; next state MEMRD for LW, MEMWR for SW. The opcode is sampled again here; IR is stable.
REQ-017 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-019 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1, then go to FETCH; mem_write stays high every stalled cycle.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 (funct decode); next state ALUWB.
REQ-021 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; next state FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, ext_sign=1; next state ADDIWB.
REQ-024 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-025 JUMP: pc_write=1, pc_src=10; next state FETCH.
REQ-026 All outputs not listed for a state SHALL be 0; outputs are Moore-decoded from state, except the mem_ready gating in REQ-013.
REQ-027 Latency from FETCH to FETCH with mem_ready held at 1: RTYPE 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, ORI 4 cycles.
REQ-028 Each clk cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle; no other state observes mem_ready.

Reset
REQ-029 rst_n=0 at a rising clk edge loads state=FETCH, from any state, including mid-stall.
REQ-030 While rst_n=0, all strobe outputs and illegal_op are forced to 0 combinationally; the select outputs are 00.
REQ-031 The first cycle after rst_n returns to 1 is a normal FETCH.

Configuration
REQ-032 Macro MIPS_CTRL_ORI_EN defined: ORI goes DECODE->ORIEX->ADDIWB. ORIEX drives alu_src_a=1, alu_src_b=10, alu_op=11 (OR), ext_sign=0 (zero-extend immediate).
REQ-033 Macro MIPS_CTRL_ORI_EN undefined: the ORIEX state is not compiled in, and ORI is treated as illegal per REQ-015.

Verification
REQ-034 Reset, then mem_ready=1, opcode=100011 (LW) -> state_dbg sequence 0,1,2,3,4,0; reg_write=1 only in state 4.
REQ-035 SW with mem_ready=0 for 3 cycles in MEMWR -> mem_write high for 4 consecutive cycles; FETCH follows on the next cycle.
REQ-036 BEQ and J back-to-back -> 3 cycles each; pc_write_cond=1/pc_src=01 in BRANCH; pc_write=1/pc_src=10 in JUMP.
REQ-037 opcode=111111 in DECODE -> illegal_op pulses for 1 cycle; next state 0. ORI without the macro gives the same result; with the macro, ORI gives 0,1,12,10,0 with ext_sign=0 in state 12.
REQ-038 rst_n=0 for 1 cycle while stalled in MEMRD -> state_dbg=0 next cycle; reg_write is never asserted for the aborted load.
